// File: rtl/canvas_pkg.sv
// Shared Tiny Canvas pixel-path types and constants.
package canvas_pkg;
    localparam int CANVAS_COORD_W = 8;
    localparam int CANVAS_COLOR_W = 3;
    localparam int PIXEL_W        = CANVAS_COORD_W * 2 + CANVAS_COLOR_W;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef struct packed {
        logic [CANVAS_COORD_W-1:0] x;
        logic [CANVAS_COORD_W-1:0] y;
        logic [CANVAS_COLOR_W-1:0] color;
    } pixel_t;

    function automatic int pixel_w(int coord_w, int color_w);
        return coord_w * 2 + color_w;
    endfunction
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered storage/head and a separate occupancy counter.
module pixel_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_q];
    assign count   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pixel_stream_arbiter.sv
// N-source pixel merger: fixed/round-robin grant, optional repeat-pixel coalescing, buffered output.
module pixel_stream_arbiter
    import canvas_pkg::*;
#(
    parameter int N_SRC    = 3,
    parameter int COORD_W  = 8,
    parameter int COLOR_W  = 3,
    parameter int DEPTH    = 8,
    parameter int ARB_MODE = 0,
    parameter int DEDUP    = 1,
    localparam int SRC_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [N_SRC-1:0]         src_valid,
    output logic [N_SRC-1:0]         src_ready,
    input  logic [N_SRC*COORD_W-1:0] src_x,
    input  logic [N_SRC*COORD_W-1:0] src_y,
    input  logic [N_SRC*COLOR_W-1:0] src_color,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COORD_W-1:0]       out_x,
    output logic [COORD_W-1:0]       out_y,
    output logic [COLOR_W-1:0]       out_color,
    output logic [SRC_W-1:0]         out_src,
    output logic [AW:0]              fill_level,
    output logic [7:0]               drop_cnt
);
    localparam int PW = pixel_w(COORD_W, COLOR_W);

    logic [SRC_W-1:0] gnt, rr_ptr_q, rr_ptr_d;
    logic             any_vld, full, empty, accept, dup, push, pop;
    logic [PW-1:0]    pix_g, last_word_q;
    logic             last_valid_q;
    logic [7:0]       drop_q;
    logic [PW+SRC_W-1:0] head;

    // Scan order starts at rr_ptr in round-robin mode, at 0 otherwise.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        any_vld = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (ARB_MODE == ARB_RR) ? int'(rr_ptr_q) + k : k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!any_vld && src_valid[idx]) begin
                any_vld = 1'b1;
                gnt     = SRC_W'(idx);
            end
        end
    end

    assign accept = any_vld & ~full & ~flush & ~rst;

    always_comb begin
        src_ready = '0;
        if (accept) src_ready[gnt] = 1'b1;
    end

    assign pix_g = {src_x[gnt*COORD_W +: COORD_W],
                    src_y[gnt*COORD_W +: COORD_W],
                    src_color[gnt*COLOR_W +: COLOR_W]};
    assign dup   = (DEDUP != 0) && last_valid_q && (pix_g == last_word_q);
    assign push  = accept & ~dup;
    assign pop   = ~empty & out_ready;

    assign rr_ptr_d = (gnt == SRC_W'(N_SRC-1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            last_word_q  <= '0;
            last_valid_q <= 1'b0;
            drop_q       <= '0;
        end else if (flush) begin
            rr_ptr_q     <= '0;
            last_valid_q <= 1'b0;
        end else if (accept) begin
            rr_ptr_q     <= rr_ptr_d;
            last_word_q  <= pix_g;
            last_valid_q <= 1'b1;
            if (dup && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
        end
    end

    pixel_fifo #(.W(PW + SRC_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({pix_g, gnt}),
        .head  (head),
        .count (fill_level),
        .empty (empty),
        .full  (full)
    );

    assign {out_x, out_y, out_color, out_src} = head;
    assign out_valid = ~empty;
    assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Bench: queue-based reference model checked every cycle, plus directed literal checks, for fixed and RR instances.
module tb_pixel_stream_arbiter;
    logic        clk = 1'b0;
    logic        rst, flush, ordy;
    logic [2:0]  sv;
    logic [23:0] sx, sy;
    logic [8:0]  sc;

    logic [2:0] rdy [2];
    logic       ov  [2];
    logic [7:0] ox  [2];
    logic [7:0] oy  [2];
    logic [2:0] oc  [2];
    logic [1:0] os  [2];
    logic [3:0] fl  [2];
    logic [7:0] dc  [2];

    always #5 clk = ~clk;

    pixel_stream_arbiter #(.ARB_MODE(0)) u_fix (
        .clk(clk), .rst(rst), .flush(flush), .src_valid(sv), .src_ready(rdy[0]),
        .src_x(sx), .src_y(sy), .src_color(sc), .out_valid(ov[0]), .out_ready(ordy),
        .out_x(ox[0]), .out_y(oy[0]), .out_color(oc[0]), .out_src(os[0]),
        .fill_level(fl[0]), .drop_cnt(dc[0]));

    pixel_stream_arbiter #(.ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .flush(flush), .src_valid(sv), .src_ready(rdy[1]),
        .src_x(sx), .src_y(sy), .src_color(sc), .out_valid(ov[1]), .out_ready(ordy),
        .out_x(ox[1]), .out_y(oy[1]), .out_color(oc[1]), .out_src(os[1]),
        .fill_level(fl[1]), .drop_cnt(dc[1]));

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue of {x,y,color,src} words per instance.
    logic [20:0] mq [2][$];
    logic [18:0] mlast [2];
    bit          mlv [2];
    int          mrr [2];
    int          mdrop [2];

    function automatic int grant(int mode, logic [2:0] v, int rr);
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (mode == 1) ? (rr + k) % 3 : k;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int g;
            logic [2:0]  er;
            logic [18:0] w;
            bit acc;
            if (rst) begin
                mq[m].delete();
                mlv[m] = 0; mrr[m] = 0; mdrop[m] = 0;
            end
            g   = grant(m, sv, mrr[m]);
            acc = !rst && !flush && mq[m].size() < 8 && g >= 0;
            er  = 3'b000;
            if (acc) er[g] = 1'b1;
            chk($sformatf("src_ready[%0d]", m), 32'(rdy[m]), 32'(er));
            chk($sformatf("out_valid[%0d]", m), 32'(ov[m]), 32'(mq[m].size() > 0));
            chk($sformatf("fill_level[%0d]", m), 32'(fl[m]), 32'(mq[m].size()));
            chk($sformatf("drop_cnt[%0d]", m), 32'(dc[m]), 32'(mdrop[m]));
            if (mq[m].size() > 0)
                chk($sformatf("out_word[%0d]", m), 32'({ox[m], oy[m], oc[m], os[m]}), 32'(mq[m][0]));
            else if (rst)
                chk($sformatf("out_word_rst[%0d]", m), 32'({ox[m], oy[m], oc[m], os[m]}), 32'd0);
            if (!rst) begin
                if (flush) begin
                    mq[m].delete();
                    mlv[m] = 0; mrr[m] = 0;
                end else begin
                    if (mq[m].size() > 0 && ordy) void'(mq[m].pop_front());
                    if (acc) begin
                        w = {sx[g*8 +: 8], sy[g*8 +: 8], sc[g*3 +: 3]};
                        if (mlv[m] && w == mlast[m]) begin
                            if (mdrop[m] < 255) mdrop[m]++;
                        end else begin
                            mq[m].push_back({w, g[1:0]});
                        end
                        mlast[m] = w; mlv[m] = 1; mrr[m] = (g + 1) % 3;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ordy = 1'b0; sv = 3'b111; sx = '0; sy = '0; sc = '0;
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        repeat (3) step();
        sv = 3'b000; rst = 1'b0;
        step();

        // Single source into empty FIFO
        sx = 24'd10; sy = 24'd20; sc = 9'b101; sv = 3'b001;
        #1 chk("t1_ready", 32'(rdy[0]), 32'b001);
        step();
        sv = 3'b000;
        chk("t1_valid", 32'(ov[0]), 32'd1);
        chk("t1_x", 32'(ox[0]), 32'd10);
        chk("t1_y", 32'(oy[0]), 32'd20);
        chk("t1_color", 32'(oc[0]), 32'd5);
        chk("t1_src", 32'(os[0]), 32'd0);
        chk("t1_fill", 32'(fl[0]), 32'd1);
        ordy = 1'b1; step(); ordy = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;

        // All sources valid: fixed always picks 0, RR cycles 0,1,2
        ordy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sx = {8'd2, 8'd1, 8'(30 + k)}; sy = {8'd2, 8'd1, 8'd0}; sc = {3'd2, 3'd1, 3'd0};
            sv = 3'b111;
            #1;
            chk("fix_ready", 32'(rdy[0]), 32'b001);
            chk("rr_ready", 32'(rdy[1]), 32'(1 << (k % 3)));
            step();
            chk("rr_out_src", 32'(os[1]), 32'(k % 3));
            chk("fix_out_src", 32'(os[0]), 32'd0);
        end
        sv = 3'b000; step();

        // Back-pressure until full, then a single pop
        flush = 1'b1; step(); flush = 1'b0;
        ordy = 1'b0; sv = 3'b010;
        for (int k = 0; k < 8; k++) begin
            sx = {8'd0, 8'(100 + k), 8'd0};
            step();
        end
        sx = {8'd0, 8'd200, 8'd0};
        chk("bp_fill8", 32'(fl[0]), 32'd8);
        chk("bp_ready0", 32'(rdy[0]), 32'd0);
        chk("bp_ready0_rr", 32'(rdy[1]), 32'd0);
        ordy = 1'b1; step(); ordy = 1'b0;
        chk("bp_fill7", 32'(fl[0]), 32'd7);
        chk("bp_ready_again", 32'(rdy[0]), 32'b010);
        step();
        chk("bp_refill", 32'(fl[0]), 32'd8);
        sv = 3'b000;

        // Dedup of a held pixel
        flush = 1'b1; step(); flush = 1'b0;
        sx = 24'd5; sy = 24'd5; sc = 9'd1; sv = 3'b001;
        repeat (6) step();
        chk("dd_fill", 32'(fl[0]), 32'd1);
        chk("dd_drop", 32'(dc[0]), 32'd5);
        sx = 24'd6; step();
        chk("dd_new", 32'(fl[0]), 32'd2);
        sx = 24'd7; step();
        sx = 24'd5; step();
        chk("dd_fill4", 32'(fl[0]), 32'd4);

        // Flush beats a simultaneous accept and clears dedup history
        flush = 1'b1;
        #1 chk("fl_ready", 32'(rdy[0]), 32'd0);
        step(); flush = 1'b0;
        chk("fl_fill", 32'(fl[0]), 32'd0);
        chk("fl_valid", 32'(ov[0]), 32'd0);
        step();
        chk("fl_rewrite", 32'(fl[0]), 32'd1);
        chk("fl_drop_kept", 32'(dc[0]), 32'd5);

        // Mid-stream asynchronous reset
        sx = {8'd9, 8'd8, 8'd7}; sv = 3'b111;
        step(); step();
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(ov[1]), 32'd0);
        chk("rst_fill", 32'(fl[1]), 32'd0);
        chk("rst_drop", 32'(dc[0]), 32'd0);
        chk("rst_x", 32'(ox[1]), 32'd0);
        chk("rst_ready_mid", 32'(rdy[1]), 32'd0);
        step();
        rst = 1'b0; sv = 3'b000;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
